alu_exec_stage: RTL
===================

// Module: alu_exec_stage
// PURPOSE
//  EX-stage datapath consumer of the 3-bit ALU control code driven by the ALU control decoder.
//  Accepts operands plus control code through a valid/ready handshake and computes the result.
//  Buffers results in a 2-entry skid buffer and presents them to the EX/MEM side with valid/ready.
//  Provides a zero flag (branch compare), an overflow flag and an illegal-code flag.
// PARAMETERS
//  WIDTH   32  operand/result width in bits (>= 2)
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  flush      in   1      synchronous: drop every buffered entry (branch taken / pipeline flush)
//  in_valid   in   1      operand bundle valid
//  in_ready   out  1      stage can accept a bundle this cycle
//  control    in   3      ALU control code (000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT)
//  op_a       in   WIDTH  operand A (rs)
//  op_b       in   WIDTH  operand B (rt or sign-extended immediate)
//  out_valid  out  1      result entry valid
//  out_ready  in   1      downstream accepts the entry this cycle
//  result     out  WIDTH  ALU result of the head entry
//  zero       out  1      result == 0 for the head entry
//  overflow   out  1      signed overflow on ADD/SUB for the head entry; 0 for other codes
//  illegal    out  1      head entry carried an unlisted control code (011, 100, 101)
// BEHAVIOUR
//  - Reset (rst_n=0, async): buffer empty, out_valid=0, result=0, zero=0, overflow=0, illegal=0;
//    in_ready=1 from the first clock edge after deassertion.
//  - Push = in_valid & in_ready. Pop = out_valid & out_ready. Transfers occur on the rising edge.
//  - in_ready = (count < 2). It is registered-state only; no combinational path from out_ready.
//  - Latency: a bundle pushed at edge N is presented at the head (out_valid=1) after edge N,
//    i.e. 1 cycle, when the buffer is empty or is popped at the same edge.
//  - Ordering strictly FIFO. Simultaneous push and pop at count=2 is impossible (in_ready=0).
//    At count=1 this leaves count=1, and the new entry becomes the head.
//  - Arithmetic is computed at push time; the stored entry holds {result, zero, overflow, illegal}.
//    ADD: a+b, wrap modulo 2^WIDTH. SUB: a-b, wrap.
//    overflow = operand signs as required by the op and result sign differs.
//    SLT: signed compare, result = {0..0, (a-b)[MSB] ^ ovf_sub}. AND/OR bitwise.
//    Illegal code: result=0, zero=1, illegal=1, overflow=0.
//  - Head outputs hold stable while out_valid=1 and out_ready=0.
//  - flush: count:=0 and out_valid:=0 at the next edge; a push in the same cycle is also dropped.
//    flush takes priority over push and pop.
//  - Holding rst_n low mid-operation discards all entries; no partial entry survives.
//  - Storage: two entry registers plus rd/wr pointers (1 bit each) and a 2-bit count.
//    Pointers wrap 1->0.
// STRUCTURE
//  - Shared package alu_defs_pkg: localparams ALU_AND=3'b000, ALU_OR=3'b001, ALU_ADD=3'b010,
//    ALU_SUB=3'b110, ALU_SLT=3'b111; the entry struct/width constant (WIDTH+3).
//  - Sub-module alu_core: purely combinational (control, a, b) -> (result, zero, overflow, illegal).
//    Instantiated once; the top level contains only the skid buffer and handshake.
// TESTING
//  1 Reset then push ADD a=5,b=7, out_ready=1 -> next cycle out_valid=1, result=12, zero=0, ovf=0.
//  2 SUB a=0x7FFFFFFF,b=0xFFFFFFFF -> result=0x80000000, overflow=1; SLT a=-1,b=1 -> result=1.
//  3 out_ready=0, push 3 back-to-back -> first two accepted, in_ready=0 on third;
//    release -> results in order, third accepted after the first pop.
//  4 count=1, push and pop at the same edge -> count stays 1; head = new entry; no loss/duplication.
//  5 count=2, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1; flushed data never appears.
//  6 control=3'b100, a=9,b=3 -> result=0, zero=1, illegal=1; assert rst_n=0 mid-stream -> outputs 0 immediately.

Source files
------------

// File: rtl/alu_defs_pkg.sv
// Shared ALU definitions: control encodings and the layout of a buffered result entry.
package alu_defs_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam int unsigned ENTRY_FLAG_BITS = 3;

  typedef struct packed {
    logic zero;
    logic overflow;
    logic illegal;
  } alu_flags_t;

  function automatic int unsigned entry_width(int unsigned width);
    return width + ENTRY_FLAG_BITS;
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: evaluates one control code on two operands and derives the status flags.
module alu_core
  import alu_defs_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [2:0]       control,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             illegal
);

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             ovf_add;
  logic             ovf_sub;

  assign sum  = a + b;
  assign diff = a - b;
  // Signed overflow: operands agree (add) or disagree (sub) in sign and the result flips it.
  assign ovf_add = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  assign ovf_sub = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);

  always_comb begin
    result   = '0;
    overflow = 1'b0;
    illegal  = 1'b0;
    case (control)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_ADD: begin
        result   = sum;
        overflow = ovf_add;
      end
      ALU_SUB: begin
        result   = diff;
        overflow = ovf_sub;
      end
      ALU_SLT: result = {{(WIDTH-1){1'b0}}, diff[WIDTH-1] ^ ovf_sub};
      default: illegal = 1'b1;
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/alu_exec_stage.sv
// EX stage: computes the ALU result at push time and holds up to two results in a skid buffer.
module alu_exec_stage
  import alu_defs_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       control,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             illegal
);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    alu_flags_t       flags;
  } entry_t;

  entry_t     mem [2];
  entry_t     new_entry;
  entry_t     head;
  logic [1:0] count;
  logic       rd_ptr;
  logic       wr_ptr;
  logic       push;
  logic       pop;

  logic [WIDTH-1:0] core_result;
  logic             core_zero;
  logic             core_ovf;
  logic             core_ill;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .control  (control),
    .a        (op_a),
    .b        (op_b),
    .result   (core_result),
    .zero     (core_zero),
    .overflow (core_ovf),
    .illegal  (core_ill)
  );

  always_comb begin
    new_entry                = '0;
    new_entry.result         = core_result;
    new_entry.flags.zero     = core_zero;
    new_entry.flags.overflow = core_ovf;
    new_entry.flags.illegal  = core_ill;
  end

  assign in_ready  = (count < 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) mem[i] <= '0;
    end else if (flush) begin
      count  <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= new_entry;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + 2'(push) - 2'(pop);
    end
  end

  // Stale storage is masked so an empty buffer always presents all-zero head outputs.
  assign head     = mem[rd_ptr];
  assign result   = out_valid ? head.result         : '0;
  assign zero     = out_valid & head.flags.zero;
  assign overflow = out_valid & head.flags.overflow;
  assign illegal  = out_valid & head.flags.illegal;

endmodule
